// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone (pipelined) arbiter.
// Grant is registered and held for the owner's whole cyc window; the bus mux is combinational.
module wb_arbiter2 #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int SW = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  // master A (UART bridge)
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  input  logic [SW-1:0] i_a_sel,
  output logic          o_a_stall,
  output logic          o_a_ack,
  output logic          o_a_err,
  output logic [DW-1:0] o_a_data,
  // master B (DMA / debug)
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  input  logic [SW-1:0] i_b_sel,
  output logic          o_b_stall,
  output logic          o_b_ack,
  output logic          o_b_err,
  output logic [DW-1:0] o_b_data,
  // slave side
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic [SW-1:0] o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data
);

  // state   | meaning
  // ST_IDLE | no owner, slave side driven to 0
  // ST_A    | master A owns the bus
  // ST_B    | master B owns the bus
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_B    = 2'd2
  } state_e;

  state_e state;
  logic   last_b;   // 1: B was granted most recently, so A wins the next tie
  logic   gnt_a;
  logic   gnt_b;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      last_b <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_a_cyc && (!i_b_cyc || last_b)) begin
            state  <= ST_A;
            last_b <= 1'b0;
          end else if (i_b_cyc) begin
            state  <= ST_B;
            last_b <= 1'b1;
          end
        end
        ST_A: begin
          if (!i_a_cyc) begin
            if (i_b_cyc) begin
              state  <= ST_B;
              last_b <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_B: begin
          if (!i_b_cyc) begin
            if (i_a_cyc) begin
              state  <= ST_A;
              last_b <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_a = (state == ST_A);
  assign gnt_b = (state == ST_B);

  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_wb_sel  = '0;
    if (gnt_a) begin
      o_wb_cyc  = i_a_cyc;
      o_wb_stb  = i_a_stb;
      o_wb_we   = i_a_we;
      o_wb_addr = i_a_addr;
      o_wb_data = i_a_data;
      o_wb_sel  = i_a_sel;
    end else if (gnt_b) begin
      o_wb_cyc  = i_b_cyc;
      o_wb_stb  = i_b_stb;
      o_wb_we   = i_b_we;
      o_wb_addr = i_b_addr;
      o_wb_data = i_b_data;
      o_wb_sel  = i_b_sel;
    end
  end

  // A late ack after an abort is dropped because the grant has already moved on.
  assign o_a_ack   = gnt_a & i_wb_ack;
  assign o_b_ack   = gnt_b & i_wb_ack;
  assign o_a_err   = gnt_a & i_wb_err;
  assign o_b_err   = gnt_b & i_wb_err;
  assign o_a_stall = !gnt_a | i_wb_stall;
  assign o_b_stall = !gnt_b | i_wb_stall;
  assign o_a_data  = i_wb_data;
  assign o_b_data  = i_wb_data;

endmodule
